pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports ihit, dhit  in  1 each  instruction fetch hit and data access hit from the cache interface.
REQ-004 SHALL have ports dmemREN_EX_MEM, dmemWEN_EX_MEM  in  1 each  load/store pending in the EX/MEM stage.
REQ-005 SHALL have ports halt_EX_MEM, pc_src_EX_MEM  in  1 each  halt, and taken branch/jump, resolved in the EX/MEM stage.
REQ-006 SHALL have ports memread_ID_EX  in  1, Rt_ID_EX  in  5, Rs_IF_ID  in  5, Rt_IF_ID  in  5  load-use hazard inputs.
REQ-007 SHALL have port pc_enable  out  1  PC register update enable.
REQ-008 SHALL have ports enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  pipeline register enables.
REQ-009 SHALL have ports flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  pipeline register flushes; a flush is asserted only while the matching enable is 1.
REQ-010 SHALL have ports halted  out  1, stall_count  out  16, mem_timeout  out  1  status outputs.

Function
REQ-011 SHALL implement FSM states RUN, MEM_WAIT, HALTED; outputs are combinational from state and inputs (Mealy).
REQ-012 SHALL define mem_busy = (dmemREN_EX_MEM | dmemWEN_EX_MEM) & ~dhit.
REQ-013 SHALL define load_use = memread_ID_EX & (Rt_ID_EX != 0) & (Rt_ID_EX == Rs_IF_ID | Rt_ID_EX == Rt_IF_ID).
REQ-014 SHALL, in RUN or MEM_WAIT, apply the first matching rule, in this priority order (rules 1-6).
REQ-015 Rule 1, mem_busy: all enables 0, all flushes 0, pc_enable 0; next state MEM_WAIT.
REQ-016 Rule 2, halt_EX_MEM: all enables 1; flush_IF_ID, flush_ID_EX, flush_EX_MEM 1; pc_enable 0; next state HALTED.
REQ-017 Rule 3, pc_src_EX_MEM: all enables 1; flush_IF_ID, flush_ID_EX, flush_EX_MEM 1; pc_enable 1 regardless of ihit; next state RUN.
REQ-018 Rule 4, load_use: pc_enable 0; enable_IF_ID 0; flush_ID_EX 1; enable_ID_EX, enable_EX_MEM, enable_MEM_WB 1; next state RUN.
REQ-019 Rule 5, ~ihit: pc_enable 0; all enables 1; flush_IF_ID 1; next state RUN.
REQ-020 Rule 6, otherwise: all enables 1, no flushes, pc_enable 1; next state RUN.
REQ-021 SHALL never assert flush_MEM_WB except during reset (REQ-026).
REQ-022 SHALL, in HALTED, drive all enables 0, all flushes 0, pc_enable 0, halted 1, and remain in HALTED until RST.
REQ-023 SHALL keep an 8-bit wait counter: cleared on entry to MEM_WAIT, incremented each cycle in MEM_WAIT while mem_busy, saturating at 255; cleared on leaving MEM_WAIT.
REQ-024 SHALL set mem_timeout sticky 1 when the wait counter equals 255 while mem_busy; pipeline behaviour is unaffected.
REQ-025 SHALL increment stall_count by 1 on each cycle in RUN or MEM_WAIT with pc_enable 0, saturating at 16'hFFFF; hold it in HALTED.

Reset
REQ-026 SHALL, while RST=1: set state RUN; clear stall_count, wait counter, mem_timeout; drive pc_enable 0, all enables 1, all four flushes 1, halted 0.
REQ-027 SHALL apply reset identically mid-stall, mid-MEM_WAIT or in HALTED; the first cycle after RST falls follows the RUN rules.

Verification
REQ-028 Load-use: memread_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5, ihit=1 -> one cycle of pc_enable=0, enable_IF_ID=0, flush_ID_EX=1; stall_count 0->1.
REQ-029 Miss: dmemREN_EX_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles with all enables 0 in MEM_WAIT; dhit cycle follows rule 6; stall_count=3.
REQ-030 Branch with I-miss: pc_src_EX_MEM=1, ihit=0 -> pc_enable=1, three flushes 1, flush_MEM_WB=0.
REQ-031 Halt: halt_EX_MEM=1 -> one cycle of flushes plus enables 1; then halted=1 with all enables 0 for 10+ cycles; RST=1 -> RUN, stall_count=0.
REQ-032 Timeout: dmemWEN_EX_MEM=1, dhit=0 for 260 cycles -> mem_timeout=1 from the 256th MEM_WAIT cycle onward; it stays 1 after dhit=1.
REQ-033 Priority: mem_busy, halt_EX_MEM, pc_src_EX_MEM and load_use all 1 -> rule 1 outputs only, next state MEM_WAIT.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: drives PC and pipeline-register enables/flushes
// from cache hits, load-use hazards, branches and halt, with stall and timeout status.
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmemREN_EX_MEM,
  input  logic        dmemWEN_EX_MEM,
  input  logic        halt_EX_MEM,
  input  logic        pc_src_EX_MEM,
  input  logic        memread_ID_EX,
  input  logic [4:0]  Rt_ID_EX,
  input  logic [4:0]  Rs_IF_ID,
  input  logic [4:0]  Rt_IF_ID,
  output logic        pc_enable,
  output logic        enable_IF_ID,
  output logic        enable_ID_EX,
  output logic        enable_EX_MEM,
  output logic        enable_MEM_WB,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        flush_EX_MEM,
  output logic        flush_MEM_WB,
  output logic        halted,
  output logic [15:0] stall_count,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       mem_busy;
  logic       load_use;
  logic [7:0] wait_count;

  assign mem_busy = (dmemREN_EX_MEM | dmemWEN_EX_MEM) & ~dhit;
  assign load_use = memread_ID_EX & (Rt_ID_EX != 5'd0) &
                    ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; only a pending memory access or a halt leaves RUN
  always_comb begin
    next_state = state;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          next_state = MEM_WAIT;
        end else if (halt_EX_MEM) begin
          next_state = HALTED;
        end else begin
          next_state = RUN;
        end
      end
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  // Mealy control outputs, first matching rule wins
  always_comb begin
    pc_enable     = 1'b0;
    enable_IF_ID  = 1'b0;
    enable_ID_EX  = 1'b0;
    enable_EX_MEM = 1'b0;
    enable_MEM_WB = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    flush_MEM_WB  = 1'b0;
    halted        = 1'b0;
    if (RST) begin
      enable_IF_ID  = 1'b1;
      enable_ID_EX  = 1'b1;
      enable_EX_MEM = 1'b1;
      enable_MEM_WB = 1'b1;
      flush_IF_ID   = 1'b1;
      flush_ID_EX   = 1'b1;
      flush_EX_MEM  = 1'b1;
      flush_MEM_WB  = 1'b1;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            pc_enable = 1'b0;
          end else if (halt_EX_MEM || pc_src_EX_MEM) begin
            // halt and taken branch share the squash; only branch redirects the PC
            pc_enable     = pc_src_EX_MEM & ~halt_EX_MEM;
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            flush_IF_ID   = 1'b1;
            flush_ID_EX   = 1'b1;
            flush_EX_MEM  = 1'b1;
          end else if (load_use) begin
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            flush_ID_EX   = 1'b1;
          end else begin
            pc_enable     = ihit;
            enable_IF_ID  = 1'b1;
            enable_ID_EX  = 1'b1;
            enable_EX_MEM = 1'b1;
            enable_MEM_WB = 1'b1;
            flush_IF_ID   = ~ihit;
          end
        end
        HALTED:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  // Stall counter, memory wait counter and sticky timeout flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count <= 16'd0;
      wait_count  <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      if ((state == RUN || state == MEM_WAIT) && !pc_enable && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end else begin
        stall_count <= stall_count;
      end
      // Any cycle that is not a busy MEM_WAIT cycle (including the entry cycle) clears it
      if (state == MEM_WAIT && mem_busy) begin
        if (wait_count != 8'd255) begin
          wait_count <= wait_count + 8'd1;
        end else begin
          wait_count <= wait_count;
        end
      end else begin
        wait_count <= 8'd0;
      end
      if (state == MEM_WAIT && mem_busy && wait_count == 8'd255) begin
        mem_timeout <= 1'b1;
      end else begin
        mem_timeout <= mem_timeout;
      end
    end
  end

endmodule
